// File: rtl/mesh_rx_pkg.sv
// Shared packet field layout, broadcast default and FSM state encoding for the
// mesh terminal receiver.
package mesh_rx_pkg;

    localparam int ID_W  = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    // Field offsets are counted down from the packet MSB, so they hold for any PAKG_SIZE.
    localparam int ID_OFS   = 0;
    localparam int ROW_OFS  = 8;
    localparam int COL_OFS  = 12;
    localparam int MODE_OFS = 16;

    localparam logic [7:0] BDCST_DEFAULT = 8'hFF;
    localparam int         TS_W          = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with show-ahead head output (zero while empty) and full/empty flags.
// A write into a full FIFO is accepted when a read retires the head in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers define which entries are valid,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mesh_term_rx.sv
// Mesh terminal receiver: pops packets from the router output port, keeps those
// addressed here (or broadcast) in a local FIFO. Optional feature: RX_TIMESTAMP_EN.
module mesh_term_rx
    import mesh_rx_pkg::*;
#(
    parameter int         PAKG_SIZE  = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] ROW_ID     = 4'd1,
    parameter logic [3:0] COL_ID     = 4'd1,
    parameter logic [7:0] BDCST      = BDCST_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pndng_i,
    input  logic [PAKG_SIZE-1:0] data_i,
    output logic                 pop_o,
    input  logic                 rd_i,
    output logic [PAKG_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic [15:0]          pkt_cnt_o,
    output logic [15:0]          misroute_cnt_o
`ifdef RX_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]      timestamp_o
`endif
);

`ifdef RX_TIMESTAMP_EN
    localparam int FIFO_W = PAKG_SIZE + TS_W;
`else
    localparam int FIFO_W = PAKG_SIZE;
`endif

    rx_state_e            state;
    rx_state_e            state_nxt;
    logic                 in_check;
    logic                 accept;
    logic                 fifo_empty;
    logic [FIFO_W-1:0]    cap_q;
    logic [FIFO_W-1:0]    fifo_dout;
    logic [PAKG_SIZE-1:0] cap_pkt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        pop_o     = 1'b0;
        in_check  = 1'b0;
        case (state)
            IDLE:    if (pndng_i && !full_o) state_nxt = POP;
            POP: begin
                pop_o     = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                in_check  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RX_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cyc_cnt <= '0;
        else       cyc_cnt <= cyc_cnt + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cap_q <= '0;
        else if (pop_o) cap_q <= {cyc_cnt, data_i};
    end

    assign timestamp_o = fifo_dout[FIFO_W-1 -: TS_W];
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cap_q <= '0;
        else if (pop_o) cap_q <= data_i;
    end
`endif

    assign cap_pkt = cap_q[PAKG_SIZE-1:0];
    assign accept  = ((cap_pkt[PAKG_SIZE-1-ROW_OFS -: ROW_W] == ROW_ID) &&
                      (cap_pkt[PAKG_SIZE-1-COL_OFS -: COL_W] == COL_ID)) ||
                     (cap_pkt[PAKG_SIZE-1-ID_OFS -: ID_W] == BDCST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_o      <= '0;
            misroute_cnt_o <= '0;
        end else if (in_check) begin
            if (accept) begin
                if (pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + 16'd1;
            end else if (misroute_cnt_o != '1) begin
                misroute_cnt_o <= misroute_cnt_o + 16'd1;
            end
        end
    end

    // IDLE refuses to pop while full, so a packet reaching CHECK always has a free slot.
    rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (in_check && accept),
        .wr_data (cap_q),
        .rd_en   (rd_i),
        .rd_data (fifo_dout),
        .full    (full_o),
        .empty   (fifo_empty)
    );

    assign data_o  = fifo_dout[PAKG_SIZE-1:0];
    assign valid_o = !fifo_empty;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Randomized self-checking bench for mesh_term_rx (default build) against a
// transaction-level model: router queue, expected FIFO queue and counters.
module tb_mesh_term_rx;

    localparam int         PAKG_SIZE  = 32;
    localparam int         FIFO_DEPTH = 16;
    localparam logic [3:0] ROW_ID     = 4'd1;
    localparam logic [3:0] COL_ID     = 4'd1;
    localparam logic [7:0] BDCST      = 8'hFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pndng_i;
    logic [31:0] data_i;
    logic        pop_o;
    logic        rd_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        full_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] misroute_cnt_o;

    always #5 clk_i = ~clk_i;

    mesh_term_rx #(
        .PAKG_SIZE  (PAKG_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ROW_ID     (ROW_ID),
        .COL_ID     (COL_ID),
        .BDCST      (BDCST)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pndng_i        (pndng_i),
        .data_i         (data_i),
        .pop_o          (pop_o),
        .rd_i           (rd_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .full_o         (full_o),
        .pkt_cnt_o      (pkt_cnt_o),
        .misroute_cnt_o (misroute_cnt_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] router_q[$];
    logic [31:0] exp_q[$];
    int          exp_pkt;
    int          exp_mis;
    int          pop_seen = 0;
    int          cyc      = 0;
    int          last_pop;
    bit          pop_pred;
    bit          cap_v;
    logic [31:0] cap_pkt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] make_pkt(input logic [7:0] id, input logic [3:0] row,
                                             input logic [3:0] col, input logic [14:0] payload);
        return {id, row, col, 1'b0, payload};
    endfunction

    function automatic bit dest_ok(input logic [31:0] p);
        return ((p[23:20] == ROW_ID) && (p[19:16] == COL_ID)) || (p[31:24] == BDCST);
    endfunction

    function automatic logic [31:0] rand_pkt();
        logic [31:0] p;
        p = $urandom;
        case ($urandom_range(0, 3))
            0: p[31:24] = BDCST;
            1: begin
                p[23:20] = ROW_ID;
                p[19:16] = COL_ID;
                if (p[31:24] == BDCST) p[31:24] = 8'h00;
            end
            default: ;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pkt  = 0;
        exp_mis  = 0;
        cap_v    = 1'b0;
        pop_pred = 1'b0;
        last_pop = -10;
    endtask

    task automatic check_outputs();
        check("pop_o", 32'(pop_o), 32'(pop_pred));
        check("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
        check("full_o", 32'(full_o), 32'(exp_q.size() == FIFO_DEPTH));
        check("data_o", data_o, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        check("pkt_cnt", 32'(pkt_cnt_o), 32'(exp_pkt));
        check("misroute_cnt", 32'(misroute_cnt_o), 32'(exp_mis));
    endtask

    // Drive one cycle of inputs, advance the model across the closing edge, then compare.
    task automatic run_cycle(input bit rd, input bit pmask);
        bit nxt;
        rd_i    = rd;
        pndng_i = (router_q.size() != 0) && pmask;
        data_i  = (router_q.size() != 0) ? router_q[0] : 32'hDEAD_0000;

        if (pop_pred) last_pop = cyc;
        // A new pop needs a pending packet, room in the buffer and 3-cycle spacing.
        nxt = pndng_i && (exp_q.size() < FIFO_DEPTH) && (cyc - last_pop >= 2);
        if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
        if (cap_v) begin
            if (dest_ok(cap_pkt)) begin
                exp_q.push_back(cap_pkt);
                if (exp_pkt < 65535) exp_pkt++;
            end else if (exp_mis < 65535) begin
                exp_mis++;
            end
        end
        cap_v = pop_pred;
        if (pop_pred) cap_pkt = data_i;
        if (pop_o && router_q.size() != 0) void'(router_q.pop_front());
        pop_pred = nxt;

        @(negedge clk_i);
        cyc++;
        if (pop_o) pop_seen++;
        check_outputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int pcyc;
        int vcyc;
        bit seen;

        rst_i   = 1'b1;
        rd_i    = 1'b0;
        pndng_i = 1'b0;
        data_i  = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_outputs();
        rst_i = 1'b0;

        // Local packet: pop, valid two cycles later, head matches, count 1.
        router_q.push_back(make_pkt(8'h00, 4'd1, 4'd1, 15'h5A));
        pcyc = -1;
        vcyc = -1;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 1'b1);
            if (pop_o && pcyc < 0) pcyc = cyc;
            if (valid_o && vcyc < 0) vcyc = cyc;
        end
        check("first_latency", 32'(vcyc - pcyc), 32'd2);
        check("first_data", data_o, make_pkt(8'h00, 4'd1, 4'd1, 15'h5A));
        check("first_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
        run_cycle(1'b1, 1'b1);

        // Wrong destination: dropped and counted.
        router_q.push_back(make_pkt(8'h01, 4'd2, 4'd3, 15'h123));
        repeat (8) run_cycle(1'b0, 1'b1);
        check("misroute_one", 32'(misroute_cnt_o), 32'd1);
        check("misroute_empty", 32'(valid_o), 32'd0);

        // Broadcast id with foreign coordinates is accepted.
        router_q.push_back(make_pkt(8'hFF, 4'd7, 4'd9, 15'h4321));
        repeat (8) run_cycle(1'b0, 1'b1);
        check("bcast_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
        run_cycle(1'b1, 1'b1);

        // Pending drops during POP: the capture is still taken exactly once.
        router_q.push_back(make_pkt(8'h02, 4'd1, 4'd1, 15'h0077));
        p0 = pop_seen;
        run_cycle(1'b0, 1'b1);
        repeat (8) run_cycle(1'b0, 1'b0);
        check("drop_pndng_pops", 32'(pop_seen - p0), 32'd1);
        repeat (4) run_cycle(1'b1, 1'b1);

        // Backpressure: 20 offered, 16 taken, then one read frees one more pop.
        for (int i = 0; i < 20; i++)
            router_q.push_back(make_pkt(8'h10 + 8'(i), 4'd1, 4'd1, 15'(i)));
        p0 = pop_seen;
        repeat (80) run_cycle(1'b0, 1'b1);
        check("fill_pops", 32'(pop_seen - p0), 32'd16);
        check("fill_full", 32'(full_o), 32'd1);
        run_cycle(1'b1, 1'b1);
        repeat (10) run_cycle(1'b0, 1'b1);
        check("fill_pops_after_rd", 32'(pop_seen - p0), 32'd17);
        repeat (70) run_cycle(1'b1, 1'b1);

        // Reset asserted while the packet sits in CHECK.
        router_q.push_back(make_pkt(8'h03, 4'd1, 4'd1, 15'h0BAD));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            run_cycle(1'b0, 1'b1);
            seen = pop_o;
        end
        check("rst_wait_pop", 32'(seen), 32'd1);
        run_cycle(1'b0, 1'b1);
        rst_i = 1'b1;
        #1;
        check("rst_pop", 32'(pop_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
        check("rst_mis_cnt", 32'(misroute_cnt_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        cyc++;
        rst_i = 1'b0;
        repeat (6) run_cycle(1'b0, 1'b1);
        check("rst_no_write", 32'(pkt_cnt_o), 32'd0);

        // Random traffic: a slow-reader phase to exercise full, then a balanced phase.
        for (int i = 0; i < 3000; i++) begin
            if (router_q.size() < 6 && $urandom_range(0, 2) == 0) router_q.push_back(rand_pkt());
            if (i < 1500) run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
            else          run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
